// File: rtl/clk_period_meas.sv
// Measures period and high time of a slow clock sampled in the clk_in domain.
// Optional continuous mode: define CLK_PERIOD_MEAS_CONT_EN.
module clk_period_meas #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             div_clk,
  input  logic             start,
  output logic             busy_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {StIdle, StWaitRise, StMeasHigh, StMeasLow} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_dly_q, sync_dly_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic                   valid_q, valid_d;

  logic             s, rise, fall, cnt_max;
  logic [CNT_W-1:0] cnt_inc;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~sync_dly_q;
  assign fall    = ~s & sync_dly_q;
  assign cnt_max = &cnt_q;
  // Saturating increment keeps the counter from wrapping on an edge taken at max.
  assign cnt_inc = cnt_max ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], div_clk};
    sync_dly_d = s;
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    timeout_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWaitRise;
          cnt_d   = '0;
        end
      end
      StWaitRise: begin
        if (rise) begin
          state_d = StMeasHigh;
          cnt_d   = CNT_W'(1);
        end else if (cnt_max) begin
          timeout_o = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StMeasHigh: begin
`ifdef CLK_PERIOD_MEAS_CONT_EN
        if (valid_q && !start) begin
          state_d = StIdle;
        end else
`endif
        if (fall) begin
          high_d  = cnt_q;
          cnt_d   = cnt_inc;
          state_d = StMeasLow;
        end else if (cnt_max) begin
          timeout_o = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StMeasLow: begin
        if (rise) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
`ifdef CLK_PERIOD_MEAS_CONT_EN
          // The closing rise opens the next measurement.
          state_d  = StMeasHigh;
          cnt_d    = CNT_W'(1);
`else
          state_d  = StIdle;
`endif
        end else if (cnt_max) begin
          timeout_o = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= StIdle;
      sync_q     <= '0;
      sync_dly_q <= 1'b0;
      cnt_q      <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      sync_dly_q <= sync_dly_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign valid_o  = valid_q;
  assign period_o = period_q;
  assign high_o   = high_q;

endmodule
